detect_sequence_generator_fsm: RTL and testbench

Serial pattern generator FSM, the transmit-side counterpart of the team's sequence detectors. It accepts a pattern word, a repeat count and an inter-pattern gap through a valid/ready start handshake. It then emits the pattern MSB-first, one bit per cycle, on a qualified serial output. It is used as stimulus source and loopback partner for the detector blocks, and as a standalone framing-pattern transmitter.

---
 rtl/detect_seq_pkg.sv | 11 +
 rtl/seq_shift_reg.sv | 32 +++
 rtl/detect_sequence_generator_fsm.sv | 109 ++++++++++
 tb/tb_detect_sequence_generator_fsm.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/detect_seq_pkg.sv
// Shared state type for the serial sequence generator/detector family.
package detect_seq_pkg;
  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 4'b0001,
    SEND = 4'b0010,
    GAP  = 4'b0100,
    DONE = 4'b1000
  } gen_state_e;
endpackage

// File: rtl/seq_shift_reg.sv
// W-bit MSB-first shift register that keeps a pattern copy for reloads.
// Zero latency: msb_o reflects the register directly; no backpressure.
module seq_shift_reg #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         reload_i,
  input  logic         shift_i,
  input  logic [W-1:0] pat_i,
  output logic         msb_o
);
  logic [W-1:0] shreg_q;
  logic [W-1:0] copy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      copy_q  <= '0;
    end else if (load_i) begin
      shreg_q <= pat_i;
      copy_q  <= pat_i;
    end else if (reload_i) begin
      shreg_q <= copy_q;
    end else if (shift_i) begin
      shreg_q <= {shreg_q[W-2:0], 1'b0};
    end
  end

  assign msb_o = shreg_q[W-1];
endmodule

// File: rtl/detect_sequence_generator_fsm.sv
// Serial pattern generator: repeats a W-bit pattern MSB-first with idle gaps between bursts.
// First bit one cycle after the start handshake; start_ready is low until the run completes.
module detect_sequence_generator_fsm
  import detect_seq_pkg::*;
#(
  parameter int W     = 6,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [W-1:0]     pattern,
  input  logic [CNT_W-1:0] repeats,
  input  logic [CNT_W-1:0] gap,
  output logic             out_bit,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);
  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

  gen_state_e       state_q, state_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [CNT_W-1:0] gap_reg_q, gap_reg_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic             sh_load, sh_reload, sh_shift, sh_msb;

  seq_shift_reg #(.W(W)) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .load_i   (sh_load),
    .reload_i (sh_reload),
    .shift_i  (sh_shift),
    .pat_i    (pattern),
    .msb_o    (sh_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rep_cnt_q <= '0;
      gap_reg_q <= '0;
      gap_cnt_q <= '0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      rep_cnt_q <= rep_cnt_d;
      gap_reg_q <= gap_reg_d;
      gap_cnt_q <= gap_cnt_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt_q;
    gap_reg_d = gap_reg_q;
    gap_cnt_d = gap_cnt_q;
    bit_idx_d = bit_idx_q;
    sh_load   = 1'b0;
    sh_reload = 1'b0;
    sh_shift  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          sh_load   = 1'b1;
          rep_cnt_d = repeats;
          gap_reg_d = gap;
          bit_idx_d = '0;
          state_d   = (repeats != '0) ? SEND : DONE;
        end
      end
      SEND: begin
        if (bit_idx_q == IDX_W'(W - 1)) begin
          if (rep_cnt_q != '0) rep_cnt_d = rep_cnt_q - CNT_W'(1);
          bit_idx_d = '0;
          if (rep_cnt_q == CNT_W'(1)) begin
            state_d = DONE;
          end else if (gap_reg_q == '0) begin
            sh_reload = 1'b1;
          end else begin
            state_d   = GAP;
            gap_cnt_d = gap_reg_q;
          end
        end else begin
          sh_shift  = 1'b1;
          bit_idx_d = bit_idx_q + IDX_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - CNT_W'(1);
        if (gap_cnt_q == CNT_W'(1)) begin
          state_d   = SEND;
          sh_reload = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign out_valid   = (state_q == SEND);
  assign out_bit     = out_valid & sh_msb;
  assign done        = (state_q == DONE);
endmodule

// File: tb/tb_detect_sequence_generator_fsm.sv
// Scoreboard bench: request-time expectations are queued; a negedge monitor checks every DUT output.
module tb_detect_sequence_generator_fsm;
  localparam int W = 6;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_valid = 1'b0;
  logic start_ready;
  logic [W-1:0] pattern = '0;
  logic [CNT_W-1:0] repeats = '0;
  logic [CNT_W-1:0] gap = '0;
  logic out_bit, out_valid, busy, done;

  detect_sequence_generator_fsm #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .pattern(pattern), .repeats(repeats), .gap(gap),
    .out_bit(out_bit), .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic b; } bit_t;
  bit_t bq[$];
  int   dq[$];
  int   ready_cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   init_done = 1'b0;
  logic [5:0] lb_win = '0;
  int   lb_n = 0;
  int   lb_hits = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor and reference model.
  initial begin : monitor
    bit   exp_rdy;
    bit_t e;
    int   dc;
    wait (init_done);
    forever begin
      @(negedge clk);
      exp_rdy = (cyc >= ready_cyc);
      chk("start_ready", start_ready, exp_rdy);
      chk("busy", busy, !exp_rdy);
      if (out_valid) begin
        if (bq.size() == 0) fail_now("unexpected_bit", cyc, -1);
        else begin
          e = bq.pop_front();
          chk("bit_cycle", cyc, e.c);
          chk("bit_value", out_bit, e.b);
        end
        lb_win = {lb_win[4:0], out_bit};
        lb_n++;
        if (lb_n >= 6 && lb_win == 6'b110011) lb_hits++;
      end else begin
        chk("idle_out_bit", out_bit, 1'b0);
        if (bq.size() != 0 && bq[0].c == cyc) begin
          e = bq.pop_front();
          fail_now("missing_bit", 0, e.c);
        end
      end
      if (done) begin
        if (dq.size() == 0) fail_now("unexpected_done", cyc, -1);
        else begin
          dc = dq.pop_front();
          chk("done_cycle", cyc, dc);
        end
      end else if (dq.size() != 0 && dq[0] == cyc) begin
        dc = dq.pop_front();
        fail_now("missing_done", 0, dc);
      end
      if (rst) begin
        bq.delete();
        dq.delete();
        ready_cyc = cyc + 1;
        lb_win = '0;
        lb_n = 0;
      end else if (start_valid && exp_rdy) begin
        for (int r = 0; r < int'(repeats); r++)
          for (int k = 0; k < W; k++)
            bq.push_back('{cyc + 1 + r * (W + int'(gap)) + k, pattern[W-1-k]});
        dc = cyc + 1 + ((repeats != 0) ? int'(repeats) * W + (int'(repeats) - 1) * int'(gap) : 0);
        dq.push_back(dc);
        ready_cyc = dc + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!start_ready && t < 300) begin
      tick();
      t++;
    end
    if (t >= 300) fail_now("ready_timeout", 0, 1);
  endtask

  task automatic do_req(input logic [W-1:0] p, input logic [CNT_W-1:0] r, input logic [CNT_W-1:0] g);
    wait_idle();
    start_valid = 1'b1;
    pattern = p;
    repeats = r;
    gap = g;
    tick();
    start_valid = 1'b0;
    pattern = W'($urandom);
    repeats = CNT_W'($urandom);
    gap = CNT_W'($urandom);
  endtask

  initial begin : driver
    int hits0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_start_ready", start_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_bit", out_bit, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 1'b0;
    init_done = 1'b1;
    tick();

    do_req(6'b110011, 4'd1, 4'd0);
    do_req(6'b101010, 4'd3, 4'd2);
    do_req(6'b111111, 4'd0, 4'd3);
    do_req(W'($urandom), 4'd2, 4'd0);

    // start_valid held through busy, with pattern churning every cycle.
    wait_idle();
    start_valid = 1'b1;
    repeats = 4'd2;
    gap = 4'd1;
    for (int i = 0; i < 60; i++) begin
      pattern = W'($urandom);
      tick();
    end
    start_valid = 1'b0;

    // Reset during the third bit of a burst.
    do_req(6'b100101, 4'd2, 4'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_start_ready", start_ready, 1'b1);
    chk("midrst_done", done, 1'b0);
    do_req(6'b011001, 4'd1, 4'd0);

    for (int i = 0; i < 15; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      do_req(W'($urandom), CNT_W'($urandom_range(0, 3)), CNT_W'($urandom_range(0, 3)));
    end

    // Loopback: overlapping-pattern detector over the valid bit stream.
    wait_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hits0 = lb_hits;
    do_req(6'b110011, 4'd4, 4'd0);
    wait_idle();
    tick();
    chk("loopback_hits", lb_hits - hits0, 4);

    repeat (3) tick();
    chk("bits_drained", bq.size(), 0);
    chk("dones_drained", dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
